// File: rtl/swd_target.sv
// SWD target responder: header decode, ACK, read-data drive, write-data capture; no backpressure, ~4 clk from SWCLK rise to outputs.
// Optional line-reset detector enabled by `define SWD_TGT_LINERESET_EN (adds lineReset output).
module swd_target #(
  parameter int SYNC_STAGES       = 2,
  parameter int LINE_RESET_CYCLES = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swclk,
  input  logic        swdi,
  output logic        swdo,
  output logic        swwr,
  output logic        apndp,
  output logic        rnw,
  output logic [1:0]  addr32,
  output logic        req,
  input  logic [2:0]  ackIn,
  input  logic [31:0] dreadIn,
  output logic [31:0] dwrite,
  output logic        wstb,
  output logic        perr,
  output logic        busy
`ifdef SWD_TGT_LINERESET_EN
  ,
  output logic        lineReset
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    TRN1  = 3'd2,
    ACK   = 3'd3,
    RDATA = 3'd4,
    TRN2  = 3'd5,
    WTRN  = 3'd6,
    WDATA = 3'd7
  } state_t;

  state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   sclk_prev;
  logic                   rise;
  logic                   sdi;

  logic [5:0]  hdr_sr;
  logic [2:0]  ack_q;
  logic [31:0] rdata_q;
  logic [31:0] wdata_sr;
  logic        hdr_ok;
  logic        hdr_valid;
  logic        ack_ok;
  logic        start_ok;

  // swclk and swdi share the same synchroniser depth so data stays aligned to the detected edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      sdi_sync  <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], swclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], swdi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sdi  = sdi_sync[SYNC_STAGES-1];

  // hdr_sr[0]=APnDP .. hdr_sr[4]=parity, hdr_sr[5]=stop; current sample is park
  assign hdr_ok    = sdi & ~hdr_sr[5] & (hdr_sr[4] == ^hdr_sr[3:0]);
  assign hdr_valid = rise && (state == HDR) && (cnt == 6'd6) && hdr_ok;
  assign ack_ok    = (ack_q == 3'b001);

`ifdef SWD_TGT_LINERESET_EN
  localparam int LRW = $clog2(LINE_RESET_CYCLES + 1);
  logic [LRW-1:0] lr_cnt;
  logic           need_zero;
  logic           lr_hit;

  assign lr_hit   = rise & ~swwr & sdi & (lr_cnt == LRW'(LINE_RESET_CYCLES - 1));
  assign start_ok = sdi & ~need_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lr_cnt    <= '0;
      need_zero <= 1'b0;
      lineReset <= 1'b0;
    end else begin
      lineReset <= lr_hit;
      if (rise) begin
        if (swwr || !sdi)
          lr_cnt <= '0;
        else if (lr_cnt != LRW'(LINE_RESET_CYCLES))
          lr_cnt <= lr_cnt + LRW'(1);
        if (lr_hit)
          need_zero <= 1'b1;
        else if (!sdi)
          need_zero <= 1'b0;
      end
    end
  end
`else
  assign start_ok = sdi;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (rise) begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            state_nxt = HDR;
            cnt_nxt   = '0;
          end
        end
        HDR: begin
          if (cnt == 6'd6) begin
            state_nxt = hdr_ok ? TRN1 : IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        TRN1: begin
          state_nxt = ACK;
          cnt_nxt   = '0;
        end
        ACK: begin
          if (cnt == 6'd2) begin
            state_nxt = (ack_ok && rnw) ? RDATA : WTRN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        RDATA: begin
          if (cnt == 6'd32) begin
            state_nxt = TRN2;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        TRN2: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
        WTRN: begin
          state_nxt = ack_ok ? WDATA : IDLE;
          cnt_nxt   = '0;
        end
        WDATA: begin
          if (cnt == 6'd32) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 6'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
`ifdef SWD_TGT_LINERESET_EN
      if (lr_hit) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
`endif
    end
  end

  // Line ownership follows state directly, so async reset releases SWDIO immediately
  always_comb begin
    swwr = 1'b0;
    swdo = 1'b0;
    busy = (state != IDLE);
    case (state)
      ACK: begin
        swwr = 1'b1;
        case (cnt[1:0])
          2'd0:    swdo = ack_q[0];
          2'd1:    swdo = ack_q[1];
          default: swdo = ack_q[2];
        endcase
      end
      RDATA: begin
        swwr = 1'b1;
        swdo = (cnt == 6'd32) ? ^rdata_q : rdata_q[cnt[4:0]];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_sr   <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      wdata_sr <= '0;
      dwrite   <= '0;
      apndp    <= 1'b0;
      rnw      <= 1'b0;
      addr32   <= '0;
      req      <= 1'b0;
      wstb     <= 1'b0;
      perr     <= 1'b0;
    end else begin
      req  <= hdr_valid;
      wstb <= 1'b0;
      if (rise) begin
        if (state == HDR && cnt < 6'd6)
          hdr_sr <= {sdi, hdr_sr[5:1]};
        if (hdr_valid) begin
          apndp  <= hdr_sr[0];
          rnw    <= hdr_sr[1];
          addr32 <= {hdr_sr[3], hdr_sr[2]};
          perr   <= 1'b0;
        end
        if (state == TRN1) begin
          ack_q   <= ackIn;
          rdata_q <= dreadIn;
        end
        if (state == WDATA) begin
          if (cnt < 6'd32) begin
            wdata_sr <= {sdi, wdata_sr[31:1]};
          end else begin
            dwrite <= wdata_sr;
            perr   <= (sdi != ^wdata_sr);
            wstb   <= (sdi == ^wdata_sr);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_swd_target.sv
// Scoreboard bench for swd_target: host-side SWD bit driver, target-driven bits checked against a queue.
module tb_swd_target;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        swclk = 1'b0;
  logic        swdi = 1'b0;
  logic        swdo, swwr, apndp, rnw, req, wstb, perr, busy;
  logic [1:0]  addr32;
  logic [2:0]  ackIn = 3'b000;
  logic [31:0] dreadIn = 32'h0;
  logic [31:0] dwrite;
`ifdef SWD_TGT_LINERESET_EN
  logic        lineReset;
`endif

  swd_target #(.SYNC_STAGES(2), .LINE_RESET_CYCLES(50)) dut (
    .clk(clk), .rst(rst), .swclk(swclk), .swdi(swdi),
    .swdo(swdo), .swwr(swwr), .apndp(apndp), .rnw(rnw), .addr32(addr32), .req(req),
    .ackIn(ackIn), .dreadIn(dreadIn), .dwrite(dwrite), .wstb(wstb), .perr(perr), .busy(busy)
`ifdef SWD_TGT_LINERESET_EN
    , .lineReset(lineReset)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  bit          exp_bits[$];
  logic [31:0] exp_wr[$];
  int          req_n = 0, wstb_n = 0, swwr_n = 0, lr_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (req) req_n++;
    if (swwr) swwr_n++;
    if (wstb) begin
      wstb_n++;
      if (exp_wr.size() == 0) chk("wstb_unexpected", 32'd1, 32'd0);
      else chk("dwrite_on_wstb", dwrite, exp_wr.pop_front());
    end
`ifdef SWD_TGT_LINERESET_EN
    if (lineReset) lr_n++;
`endif
  end

  // One SWCLK cycle: host bit set during low phase, target output sampled just before the rising edge
  task automatic sw_bit(input logic b);
    logic d, w;
    swdi = b;
    #79;
    d = swdo;
    w = swwr;
    if (w) begin
      if (exp_bits.size() == 0) chk("swdo_unexpected_drive", 32'd1, 32'd0);
      else chk("swdo", 32'(d), 32'(exp_bits.pop_front()));
    end
    #1 swclk = 1'b1;
    #80 swclk = 1'b0;
  endtask

  task automatic send_hdr(input logic ap, input logic rw, input logic a2, input logic a3,
                          input logic par_flip, input logic park);
    sw_bit(1'b1);
    sw_bit(ap);
    sw_bit(rw);
    sw_bit(a2);
    sw_bit(a3);
    sw_bit(ap ^ rw ^ a2 ^ a3 ^ par_flip);
    sw_bit(1'b0);
    sw_bit(park);
  endtask

  task automatic do_read(input logic ap, input logic [1:0] a, input logic [2:0] ack, input logic [31:0] d);
    int r0;
    r0 = req_n;
    ackIn = ack;
    dreadIn = d;
    for (int i = 0; i < 3; i++) exp_bits.push_back(ack[i]);
    if (ack == 3'b001) begin
      for (int i = 0; i < 32; i++) exp_bits.push_back(d[i]);
      exp_bits.push_back(^d);
    end
    send_hdr(ap, 1'b1, a[0], a[1], 1'b0, 1'b1);
    chk("rd_req_pulse", req_n - r0, 1);
    chk("rd_addr32", 32'(addr32), 32'(a));
    chk("rd_rnw", 32'(rnw), 1);
    chk("rd_apndp", 32'(apndp), 32'(ap));
    chk("rd_perr_clear", 32'(perr), 0);
    if (ack == 3'b001) repeat (38) sw_bit(1'b0);
    else repeat (5) sw_bit(1'b0);
    chk("rd_busy_end", 32'(busy), 0);
    chk("rd_sb_empty", exp_bits.size(), 0);
    ackIn = 3'b000;
    dreadIn = 32'h0;
  endtask

  task automatic do_write(input logic ap, input logic [1:0] a, input logic [31:0] d, input logic par_flip);
    int r0, w0;
    r0 = req_n;
    w0 = wstb_n;
    ackIn = 3'b001;
    exp_bits.push_back(1'b1);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b0);
    if (!par_flip) exp_wr.push_back(d);
    send_hdr(ap, 1'b0, a[0], a[1], 1'b0, 1'b1);
    chk("wr_req_pulse", req_n - r0, 1);
    chk("wr_addr32", 32'(addr32), 32'(a));
    chk("wr_rnw", 32'(rnw), 0);
    repeat (5) sw_bit(1'b0);
    for (int i = 0; i < 32; i++) sw_bit(d[i]);
    sw_bit((^d) ^ par_flip);
    sw_bit(1'b0);
    chk("wr_dwrite", dwrite, d);
    chk("wr_perr", 32'(perr), 32'(par_flip));
    chk("wr_wstb_count", wstb_n - w0, par_flip ? 0 : 1);
    chk("wr_busy_end", 32'(busy), 0);
    chk("wr_sb_empty", exp_bits.size() + exp_wr.size(), 0);
    ackIn = 3'b000;
  endtask

  task automatic bad_hdr(input logic par_flip, input logic park);
    int r0, s0;
    r0 = req_n;
    s0 = swwr_n;
    send_hdr(1'b1, 1'b1, 1'b1, 1'b0, par_flip, park);
    repeat (4) sw_bit(1'b0);
    chk("bad_no_req", req_n - r0, 0);
    chk("bad_no_swwr", swwr_n - s0, 0);
    chk("bad_busy", 32'(busy), 0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  ra;
    #22;
    chk("rst_swdo", 32'(swdo), 0);
    chk("rst_swwr", 32'(swwr), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_wstb", 32'(wstb), 0);
    chk("rst_perr", 32'(perr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dwrite", dwrite, 0);
    chk("rst_fields", {27'b0, apndp, rnw, addr32}, 0);
    rst = 1'b1;
    #20;
    repeat (3) sw_bit(1'b0);

    do_read(1'b1, 2'b01, 3'b001, 32'habcdef12);
    do_write(1'b1, 2'b01, 32'habcdef12, 1'b0);
    do_write(1'b1, 2'b01, 32'habcdef12, 1'b1);
    do_read(1'b0, 2'b10, 3'b001, 32'h5a5a0ff0);
    do_read(1'b1, 2'b11, 3'b010, 32'hdeadbeef);
    do_read(1'b0, 2'b00, 3'b100, 32'h12345678);

    bad_hdr(1'b1, 1'b1);
    bad_hdr(1'b0, 1'b0);
    do_read(1'b1, 2'b00, 3'b001, 32'h00000000);

    for (int k = 0; k < 4; k++) begin
      rd = $urandom;
      ra = 2'($urandom_range(0, 3));
      if (k % 2 == 1) do_write(ra[0], ra, rd, 1'b0);
      else do_read(ra[1], ra, 3'b001, rd);
    end

    // abort a read mid-data with async reset
    ackIn = 3'b001;
    dreadIn = 32'hffffffff;
    for (int i = 0; i < 3; i++) exp_bits.push_back(ackIn[i]);
    for (int i = 0; i < 33; i++) exp_bits.push_back(1'b1);
    send_hdr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (15) sw_bit(1'b0);
    chk("mid_swwr_before", 32'(swwr), 1);
    #4 rst = 1'b0;
    #2;
    chk("mid_rst_swwr", 32'(swwr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_swdo", 32'(swdo), 0);
    exp_bits.delete();
    #24 rst = 1'b1;
    #10;
    repeat (2) sw_bit(1'b0);
    do_read(1'b0, 2'b01, 3'b001, 32'hc0ffee01);

`ifdef SWD_TGT_LINERESET_EN
    begin
      int l0, r0;
      l0 = lr_n;
      r0 = req_n;
      repeat (50) sw_bit(1'b1);
      chk("lr_pulse", lr_n - l0, 1);
      chk("lr_busy", 32'(busy), 0);
      repeat (4) sw_bit(1'b1);
      chk("lr_need_zero_busy", 32'(busy), 0);
      chk("lr_saturated", lr_n - l0, 1);
      chk("lr_no_req", req_n - r0, 0);
      sw_bit(1'b0);
      do_read(1'b1, 2'b01, 3'b001, 32'habcdef12);
    end
`endif

    chk("final_wr_queue", exp_wr.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/swd_target.md
Name: swd_target

Overview:
- SWD target-side responder: the far end of the host SWD interface. It receives request packets on SWCLK/SWDIO, returns an ACK, and either drives read data or captures write data.
- Sits between the SWD pins and a register model (DP/AP emulation).
- Serves as a bench target for the host interface and as an emulated DP.
- Samples SWCLK with the system clock; clk must be at least 4x the SWCLK frequency.

Parameters:
SYNC_STAGES, 2, synchroniser depth on swclk and swdi.
LINE_RESET_CYCLES, 50, consecutive high SWDIO samples that constitute a line reset (used only with the optional feature).

Ports:
clk  input  1  system clock.
rst  input  1  reset; asynchronous, active-low.
swclk  input  1  SWD clock from host.
swdi  input  1  SWDIO level from pin.
swdo  output  1  SWDIO value driven by target.
swwr  output  1  1 = target drives SWDIO.
apndp  output  1  request AP(1)/DP(0); held from header decode to next header.
rnw  output  1  request read(1)/write(0); held likewise.
addr32  output  2  request address bits 3:2; held likewise.
req  output  1  one-clk pulse when a valid header is decoded.
ackIn  input  3  ACK to return; sampled at the first ACK edge.
dreadIn  input  32  read data; sampled at the first ACK edge.
dwrite  output  32  captured write data.
wstb  output  1  one-clk pulse when write data with good parity is captured.
perr  output  1  write-data parity error of the last transfer.
busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - swdo=0, swwr=0, req=0, wstb=0, perr=0, busy=0.
  - dwrite=0, addr32=0, rnw=0, apndp=0.
  - state=IDLE.
- SWCLK handling:
  - swclk and swdi each pass through SYNC_STAGES flops.
  - A rising edge is detected on the synchronised swclk.
- Bit timing:
  - Target samples SWDIO on each detected swclk rising edge.
  - Target updates swdo/swwr on the same rising edge, after sampling.
  - Bits are sent and received LSB first.
- States:
  - IDLE: hunt for a sampled 1 (start bit) -> HDR.
  - HDR: shift in 7 bits: APnDP, RnW, A2, A3, parity, stop, park.
    - Valid header requires: stop=0, park=1, even parity over APnDP/RnW/A2/A3 matching the parity bit.
    - Valid -> latch request fields, pulse req on the next clk, -> TRN1.
    - Invalid -> IDLE; swwr stays 0.
  - TRN1: one SWCLK cycle, not driven. At its end set swwr=1 -> ACK.
  - ACK: drive ackIn[0], ackIn[1], ackIn[2] on three successive edges.
    - ackIn and dreadIn are latched on the first ACK edge.
    - ACK=001 with rnw=1 -> RDATA.
    - ACK=001 with rnw=0 -> WTRN.
    - Any other ACK -> WTRN, then IDLE with no data phase.
  - RDATA: drive 32 data bits, then one bit of even parity over the data; 33 edges total.
    - Then swwr=0 -> TRN2.
  - TRN2: one cycle -> IDLE.
  - WTRN: swwr=0 on entry; one cycle -> WDATA (ACK OK) or IDLE (other ACK).
  - WDATA: sample 32 data bits plus parity.
    - On the parity edge: load dwrite.
    - Good parity -> perr=0 and pulse wstb for one clk.
    - Bad parity -> perr=1, no wstb.
    - Then -> IDLE.
- perr is cleared at the next valid header.
- swwr is 1 only in the ACK and RDATA states.
- Between packets the host may hold SWDIO low for any number of idle cycles; this is treated as IDLE.
- An asynchronous reset mid-packet immediately releases the line (swwr=0) and returns to IDLE.
- Read data/parity framing: 32 data bits then parity; the parity bit is the 33rd bit after ACK.

Optional Feature:
SWD_TGT_LINERESET_EN
- With the macro defined:
  - A counter counts consecutive sampled highs while swwr=0, saturating at LINE_RESET_CYCLES.
  - On reaching LINE_RESET_CYCLES, an extra output lineReset pulses for one clk and state is forced to IDLE from any receive state.
  - A subsequent start bit is accepted only after at least one sampled 0.
- Without the macro:
  - No counter and no lineReset port.
  - Long high sequences are just repeated start/header attempts, each rejected on a bad stop/park.

Test Plan:
- Read OK: header AP=1, RnW=1, A=01, ackIn=001, dreadIn=abcdef12 -> req pulse, addr32=01, target drives ACK bits 1,0,0, data LSB-first, parity=1, swwr released at TRN2.
- Write OK: header AP=1, RnW=0, A=01, ackIn=001, host sends abcdef12 with correct parity -> dwrite=abcdef12, one wstb pulse, perr=0.
- Write parity error: same as Write OK but parity inverted -> dwrite=abcdef12, perr=1, no wstb.
- WAIT: ackIn=010 on a read -> ACK 0,1,0 driven, no data phase, busy=0 within 2 SWCLK cycles.
- Bad header: header parity wrong (or park=0) -> no req, swwr never asserted, next valid packet is accepted normally.
- Line reset (feature on): 50 highs mid-HDR -> lineReset pulse, state IDLE; after one 0 a valid read succeeds. Reset asserted mid-RDATA -> swwr=0 asynchronously.
